// File: rtl/fft_out_serializer.sv
// Ping-pong buffered serializer for a parallel FFT result block.
// It captures N complex samples at once and streams them one per cycle over valid/ready.
module fft_out_serializer #(
  parameter int OUT_WIDTH = 13,
  parameter int N         = 16,
  parameter int BITREV    = 1,
  localparam int LOG2N    = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [0:OUT_WIDTH*N-1] in_re,
  input  logic [0:OUT_WIDTH*N-1] in_im,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_WIDTH-1:0]   m_re,
  output logic [OUT_WIDTH-1:0]   m_im,
  output logic [LOG2N-1:0]       m_idx,
  output logic                   m_last,
  output logic                   drop,
  output logic [7:0]             drop_cnt
);

  logic [OUT_WIDTH-1:0] bank_re [0:1][0:N-1];
  logic [OUT_WIDTH-1:0] bank_im [0:1][0:N-1];

  logic             wr_sel, rd_sel;
  logic [1:0]       cnt;
  logic [LOG2N-1:0] rd_idx, rd_addr;
  logic             xfer, last_xfer, slot_free, capture, drop_now;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = x[LOG2N-1-b];
    return r;
  endfunction

  // A full buffer still accepts a block when the last sample of the draining bank leaves on this edge
  always_comb begin
    xfer      = m_valid & m_ready;
    last_xfer = xfer & m_last;
    slot_free = (cnt < 2'd2) | last_xfer;
    capture   = in_valid & slot_free;
    drop_now  = in_valid & ~slot_free;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int m = 0; m < N; m++) begin
        bank_re[wr_sel][m] <= in_re[m*OUT_WIDTH +: OUT_WIDTH];
        bank_im[wr_sel][m] <= in_im[m*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      cnt      <= 2'd0;
      rd_idx   <= '0;
      drop     <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      drop <= drop_now;
      if (drop_now && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (capture) wr_sel <= ~wr_sel;
      if (xfer) begin
        if (m_last) begin
          rd_idx <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          rd_idx <= rd_idx + LOG2N'(1);
        end
      end
      case ({capture, last_xfer})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Outputs are forced to zero whenever no sample is valid
  always_comb begin
    rd_addr = (BITREV != 0) ? bitrev(rd_idx) : rd_idx;
    m_valid = (cnt != 2'd0);
    m_re    = '0;
    m_im    = '0;
    m_idx   = '0;
    m_last  = 1'b0;
    if (m_valid) begin
      m_re   = bank_re[rd_sel][rd_addr];
      m_im   = bank_im[rd_sel][rd_addr];
      m_idx  = rd_idx;
      m_last = (rd_idx == LOG2N'(N-1));
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer; a natural-order and a bit-reversed instance
// share all inputs so both orderings are checked against the same stimulus.
module tb_fft_out_serializer;
  localparam int W = 13;
  localparam int N = 16;
  localparam int L = 4;

  logic           clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, m_ready = 1'b0;
  logic [0:W*N-1] in_re = '0, in_im = '0;
  logic           v0, v1, last0, last1, drop0, drop1;
  logic [W-1:0]   re0, im0, re1, im1;
  logic [L-1:0]   idx0, idx1;
  logic [7:0]     dc0, dc1;
  int             checks = 0, errors = 0;
  int             rev_tbl [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_out_serializer #(.OUT_WIDTH(W), .N(N), .BITREV(0)) dut_nat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .m_valid(v0), .m_ready(m_ready), .m_re(re0), .m_im(im0), .m_idx(idx0),
    .m_last(last0), .drop(drop0), .drop_cnt(dc0));

  fft_out_serializer #(.OUT_WIDTH(W), .N(N), .BITREV(1)) dut_rev (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .m_valid(v1), .m_ready(m_ready), .m_re(re1), .m_im(im1), .m_idx(idx1),
    .m_last(last1), .drop(drop1), .drop_cnt(dc1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element m of a block carries re = base+m, im = -(base+m)
  task automatic set_block(input int base);
    for (int m = 0; m < N; m++) begin
      in_re[m*W +: W] = W'(base + m);
      in_im[m*W +: W] = W'(-(base + m));
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_ready = 1'b1;
    set_block(50);
    for (int k = 0; k < 4; k++) begin
      in_valid = k[0];
      step();
      checks++;
      if ({v0, v1, drop1, dc1} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("[TB] FAIL reset_hold got v0=%b v1=%b drop=%b cnt=%0d exp 0 0 0 0", v0, v1, drop1, dc1);
      end
    end
    in_valid = 1'b0;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({v0, v1, drop1} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_idle got v0=%b v1=%b drop=%b exp 0 0 0", v0, v1, drop1);
      end
    end
  endtask

  task automatic test_natural();
    set_block(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({v0, re0, im0, idx0, last0} !== {1'b1, W'(i), W'(-i), L'(i), i == 15}) begin
        errors++;
        $display("[TB] FAIL natural_%0d got v=%b re=%0d im=%h idx=%0d last=%b exp re=%0d im=%h idx=%0d",
                 i, v0, re0, im0, idx0, last0, i, W'(-i), i);
      end
      step();
    end
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL natural_end got v=%b exp 0", v0);
    end
  endtask

  task automatic test_bitrev();
    set_block(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({v1, re1, im1, idx1, last1} !== {1'b1, W'(rev_tbl[i]), W'(-rev_tbl[i]), L'(i), i == 15}) begin
        errors++;
        $display("[TB] FAIL bitrev_%0d got v=%b re=%0d idx=%0d last=%b exp re=%0d idx=%0d",
                 i, v1, re1, idx1, last1, rev_tbl[i], i);
      end
      step();
    end
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bitrev_end got v=%b exp 0", v1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] saved;
    int exp_i;
    bit stalled;
    exp_i = 0;
    stalled = 1'b0;
    saved = '0;
    m_ready = 1'b0;
    set_block(100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 80 && exp_i < N; c++) begin
      if (stalled) begin
        checks++;
        if ({v1, re1, im1, idx1, last1} !== saved) begin
          errors++;
          $display("[TB] FAIL stall_hold got %h exp %h", {v1, re1, im1, idx1, last1}, saved);
        end
      end
      m_ready = (c % 3 == 0);
      if (m_ready) begin
        checks++;
        if ({v1, re1, im1, idx1} !== {1'b1, W'(100 + rev_tbl[exp_i]), W'(-(100 + rev_tbl[exp_i])), L'(exp_i)}) begin
          errors++;
          $display("[TB] FAIL bp_sample_%0d got v=%b re=%0d idx=%0d exp re=%0d idx=%0d",
                   exp_i, v1, re1, idx1, 100 + rev_tbl[exp_i], exp_i);
        end
        exp_i++;
        stalled = 1'b0;
      end else begin
        saved = {v1, re1, im1, idx1, last1};
        stalled = 1'b1;
      end
      step();
    end
    m_ready = 1'b0;
    checks++;
    if (exp_i != N || v1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_done got samples=%0d v=%b exp samples=16 v=0", exp_i, v1);
    end
  endtask

  task automatic test_full_buffer();
    int base;
    m_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      in_valid = (c == 1 || c == 5 || c == 9);
      set_block(c == 1 ? 300 : (c == 5 ? 400 : 500));
      step();
      checks++;
      if (drop1 !== (c == 9)) begin
        errors++;
        $display("[TB] FAIL full_drop_c%0d got drop=%b exp %b", c, drop1, c == 9);
      end
      in_valid = 1'b0;
    end
    checks++;
    if ({dc0, dc1} !== {8'd1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL full_drop_cnt got %0d/%0d exp 1", dc0, dc1);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 2*N; k++) begin
      base = (k < N) ? 300 : 400;
      checks++;
      if ({v1, re1, idx1, last1} !== {1'b1, W'(base + rev_tbl[k%N]), L'(k%N), (k%N) == 15}) begin
        errors++;
        $display("[TB] FAIL full_stream_%0d got v=%b re=%0d idx=%0d last=%b exp re=%0d idx=%0d",
                 k, v1, re1, idx1, last1, base + rev_tbl[k%N], k%N);
      end
      step();
    end
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_end got v=%b exp 0", v1);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    m_ready = 1'b0;
    set_block(600);
    in_valid = 1'b1;
    step();
    set_block(700);
    step();
    in_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 3*N; k++) begin
      base = 600 + 100*(k/N);
      checks++;
      if ({v1, re1, idx1, last1} !== {1'b1, W'(base + rev_tbl[k%N]), L'(k%N), (k%N) == 15}) begin
        errors++;
        $display("[TB] FAIL b2b_stream_%0d got v=%b re=%0d idx=%0d exp re=%0d idx=%0d",
                 k, v1, re1, idx1, base + rev_tbl[k%N], k%N);
      end
      if (k == 15) begin
        set_block(800);
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      if (k == 15) begin
        checks++;
        if (drop1 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_no_drop got drop=%b exp 0", drop1);
        end
      end
    end
    checks++;
    if ({v1, dc1} !== {1'b0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL b2b_end got v=%b drop_cnt=%0d exp v=0 drop_cnt=1", v1, dc1);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    set_block(900);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({v1, idx1, re1} !== {1'b1, L'(7), W'(900 + rev_tbl[7])}) begin
      errors++;
      $display("[TB] FAIL mid_pre got v=%b idx=%0d re=%0d exp v=1 idx=7 re=%0d", v1, idx1, re1, 900 + rev_tbl[7]);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({v1, re1, im1, idx1, last1, dc1} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got v=%b re=%0d idx=%0d drop_cnt=%0d exp all 0", v1, re1, idx1, dc1);
    end
    #3 rstn = 1'b1;
    step();
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_idle got v=%b exp 0", v1);
    end
    set_block(1000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({v1, re1, idx1, last1} !== {1'b1, W'(1000 + rev_tbl[i]), L'(i), i == 15}) begin
        errors++;
        $display("[TB] FAIL mid_stream_%0d got v=%b re=%0d idx=%0d exp re=%0d idx=%0d",
                 i, v1, re1, idx1, 1000 + rev_tbl[i], i);
      end
      step();
    end
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_end got v=%b exp 0", v1);
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_full_buffer();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
